// File: rtl/network_transmit_desc_sched.sv
// Per-outport TSN transmit descriptor scheduler: round-robin host/network intake
// into a per-port FIFO, and an in-order gated bufid issue handshake per port.
`default_nettype none

module network_transmit_desc_sched #(
  parameter int NUM_PORTS   = 2,
  parameter int QUEUE_DEPTH = 16,
  parameter int BUFID_W     = 9,
  parameter int TAG_W       = 48,
  localparam int QL_W       = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_PORTS*TAG_W-1:0]     iv_tsntag_host,
  input  logic [NUM_PORTS*3-1:0]         iv_pkt_type_host,
  input  logic [NUM_PORTS*BUFID_W-1:0]   iv_bufid_host,
  input  logic [NUM_PORTS-1:0]           i_descriptor_wr_host,
  output logic [NUM_PORTS-1:0]           o_descriptor_ack_host,
  input  logic [NUM_PORTS*TAG_W-1:0]     iv_tsntag_network,
  input  logic [NUM_PORTS*3-1:0]         iv_pkt_type_network,
  input  logic [NUM_PORTS*BUFID_W-1:0]   iv_bufid_network,
  input  logic [NUM_PORTS-1:0]           i_descriptor_wr_network,
  output logic [NUM_PORTS-1:0]           o_descriptor_ack_network,
  input  logic [NUM_PORTS-1:0]           i_gate_open,
  output logic [NUM_PORTS*BUFID_W-1:0]   ov_pkt_bufid,
  output logic [NUM_PORTS*3-1:0]         ov_pkt_type,
  output logic [NUM_PORTS*TAG_W-1:0]     ov_tsntag,
  output logic [NUM_PORTS-1:0]           o_pkt_bufid_wr,
  input  logic [NUM_PORTS-1:0]           i_pkt_bufid_ack,
  output logic [NUM_PORTS-1:0]           o_pkt_cnt_pulse,
  output logic [NUM_PORTS-1:0]           o_fifo_overflow_pulse,
  output logic [NUM_PORTS*QL_W-1:0]      ov_queue_level
);

  localparam int DW    = TAG_W + 3 + BUFID_W;
  localparam int PTR_W = (QUEUE_DEPTH > 2) ? $clog2(QUEUE_DEPTH) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [DW-1:0]    mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [QL_W-1:0]  level_q, level_d;
    logic             rr_net_q, rr_net_d;
    logic             ack_h_q, ack_h_d, ack_n_q, ack_n_d;
    logic             stall_q, ovf_q, ovf_d;
    state_t           state_q, state_d;
    logic [DW-1:0]    out_q, out_d;
    logic             wr_q, wr_d, cnt_q, cnt_d;
    logic             elig_h, elig_n, full, take_net, push, pop, stall;
    logic [DW-1:0]    win_desc;

    // A source whose ack is still high is holding an already-accepted request.
    assign elig_h   = i_descriptor_wr_host[p] & ~ack_h_q;
    assign elig_n   = i_descriptor_wr_network[p] & ~ack_n_q;
    assign full     = (level_q == QL_W'(QUEUE_DEPTH));
    assign push     = ~full & (elig_h | elig_n);
    assign take_net = elig_n & (~elig_h | rr_net_q);
    assign stall    = (i_descriptor_wr_host[p] | i_descriptor_wr_network[p]) & full;
    assign win_desc = take_net
        ? {iv_tsntag_network[p*TAG_W +: TAG_W], iv_pkt_type_network[p*3 +: 3],
           iv_bufid_network[p*BUFID_W +: BUFID_W]}
        : {iv_tsntag_host[p*TAG_W +: TAG_W], iv_pkt_type_host[p*3 +: 3],
           iv_bufid_host[p*BUFID_W +: BUFID_W]};

    always_comb begin
      state_d = state_q;
      out_d   = out_q;
      wr_d    = wr_q;
      cnt_d   = 1'b0;
      pop     = 1'b0;
      case (state_q)
        S_IDLE: begin
          if ((level_q != '0) && i_gate_open[p]) begin
            state_d = S_REQ;
            out_d   = mem_q[rptr_q];
            wr_d    = 1'b1;
          end
        end
        S_REQ: begin
          if (i_pkt_bufid_ack[p]) begin
            state_d = S_IDLE;
            wr_d    = 1'b0;
            cnt_d   = 1'b1;
            pop     = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_comb begin
      ack_h_d  = push & ~take_net;
      ack_n_d  = push & take_net;
      rr_net_d = push ? ~take_net : rr_net_q;
      ovf_d    = stall & ~stall_q;
      wptr_d   = push ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d   = pop ? rptr_q + PTR_W'(1) : rptr_q;
      level_d  = level_q;
      if (push && !pop) level_d = level_q + QL_W'(1);
      else if (!push && pop) level_d = level_q - QL_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        wptr_q   <= '0;
        rptr_q   <= '0;
        level_q  <= '0;
        rr_net_q <= 1'b0;
        ack_h_q  <= 1'b0;
        ack_n_q  <= 1'b0;
        stall_q  <= 1'b0;
        ovf_q    <= 1'b0;
        state_q  <= S_IDLE;
        out_q    <= '0;
        wr_q     <= 1'b0;
        cnt_q    <= 1'b0;
      end else begin
        wptr_q   <= wptr_d;
        rptr_q   <= rptr_d;
        level_q  <= level_d;
        rr_net_q <= rr_net_d;
        ack_h_q  <= ack_h_d;
        ack_n_q  <= ack_n_d;
        stall_q  <= stall;
        ovf_q    <= ovf_d;
        state_q  <= state_d;
        out_q    <= out_d;
        wr_q     <= wr_d;
        cnt_q    <= cnt_d;
      end
    end

    always_ff @(posedge i_clk) begin
      if (push) mem_q[wptr_q] <= win_desc;
    end

    assign o_descriptor_ack_host[p]             = ack_h_q;
    assign o_descriptor_ack_network[p]          = ack_n_q;
    assign o_pkt_bufid_wr[p]                    = wr_q;
    assign o_pkt_cnt_pulse[p]                   = cnt_q;
    assign o_fifo_overflow_pulse[p]             = ovf_q;
    assign ov_queue_level[p*QL_W +: QL_W]       = level_q;
    assign ov_tsntag[p*TAG_W +: TAG_W]          = out_q[DW-1 -: TAG_W];
    assign ov_pkt_type[p*3 +: 3]                = out_q[BUFID_W +: 3];
    assign ov_pkt_bufid[p*BUFID_W +: BUFID_W]   = out_q[BUFID_W-1:0];
  end

endmodule

`default_nettype wire

// File: tb/tb_network_transmit_desc_sched.sv
// Scoreboard bench for network_transmit_desc_sched: directed intake vectors push
// expected descriptors; a negedge monitor acks issues and checks order/data.
`default_nettype none

module tb_network_transmit_desc_sched;
  localparam int NP = 4;
  localparam int QD = 16;
  localparam int QLW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP*48-1:0] tag_h = '0, tag_n = '0;
  logic [NP*3-1:0]  typ_h = '0, typ_n = '0;
  logic [NP*9-1:0]  bid_h = '0, bid_n = '0;
  logic [NP-1:0]    wr_h = '0, wr_n = '0, gate = '1, back = '0;
  logic [NP-1:0]    ack_h, ack_n, bwr, cntp, ovfp;
  logic [NP*9-1:0]  o_bid;
  logic [NP*3-1:0]  o_typ;
  logic [NP*48-1:0] o_tag;
  logic [NP*QLW-1:0] lvl;

  network_transmit_desc_sched #(
    .NUM_PORTS(NP), .QUEUE_DEPTH(QD), .BUFID_W(9), .TAG_W(48)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .iv_tsntag_host(tag_h), .iv_pkt_type_host(typ_h), .iv_bufid_host(bid_h),
    .i_descriptor_wr_host(wr_h), .o_descriptor_ack_host(ack_h),
    .iv_tsntag_network(tag_n), .iv_pkt_type_network(typ_n), .iv_bufid_network(bid_n),
    .i_descriptor_wr_network(wr_n), .o_descriptor_ack_network(ack_n),
    .i_gate_open(gate), .ov_pkt_bufid(o_bid), .ov_pkt_type(o_typ), .ov_tsntag(o_tag),
    .o_pkt_bufid_wr(bwr), .i_pkt_bufid_ack(back), .o_pkt_cnt_pulse(cntp),
    .o_fifo_overflow_pulse(ovfp), .ov_queue_level(lvl)
  );

  initial forever #5 clk = ~clk;

  int ncmp = 0;
  int nmis = 0;
  logic [59:0] exp_q [NP][$];
  int cnt_seen [NP];
  int ovf_seen [NP];
  int delay [NP];
  int wcnt [NP];
  logic [NP-1:0] prev_ack = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    ncmp++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [59:0] mk(input logic [47:0] t, input logic [2:0] ty, input logic [8:0] b);
    return {t, ty, b};
  endfunction

  function automatic logic [QLW-1:0] level_of(input int p);
    return lvl[p*QLW +: QLW];
  endfunction

  // Monitor / responder: acks each issue after delay[p] cycles and checks it against the scoreboard.
  initial begin
    for (int p = 0; p < NP; p++) begin
      cnt_seen[p] = 0; ovf_seen[p] = 0; delay[p] = 0; wcnt[p] = 0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (!rst_n) begin
          back[p] = 1'b0; wcnt[p] = 0; prev_ack[p] = 1'b0;
        end else begin
          if (prev_ack[p] || cntp[p])
            chk($sformatf("cnt_pulse_p%0d", p), {63'd0, cntp[p]}, {63'd0, prev_ack[p]});
          cnt_seen[p] += int'(cntp[p]);
          ovf_seen[p] += int'(ovfp[p]);
          if (bwr[p]) begin
            if (exp_q[p].size() == 0) begin
              ncmp++; nmis++;
              $display("FAIL unexpected_issue_p%0d actual bufid=%0h required=none", p, o_bid[p*9 +: 9]);
            end else begin
              chk($sformatf("issue_data_p%0d", p),
                  {4'd0, o_tag[p*48 +: 48], o_typ[p*3 +: 3], o_bid[p*9 +: 9]}, {4'd0, exp_q[p][0]});
            end
            wcnt[p]++;
            if (wcnt[p] > delay[p]) begin
              back[p] = 1'b1;
              if (exp_q[p].size() != 0) void'(exp_q[p].pop_front());
            end else begin
              back[p] = 1'b0;
            end
          end else begin
            wcnt[p] = 0;
            back[p] = 1'b0;
          end
          prev_ack[p] = back[p];
        end
      end
    end
  end

  task automatic do_write(input int p, input bit net, input logic [59:0] d, output int lat);
    bit got;
    @(negedge clk); #1;
    if (net) begin
      tag_n[p*48 +: 48] = d[59:12]; typ_n[p*3 +: 3] = d[11:9]; bid_n[p*9 +: 9] = d[8:0]; wr_n[p] = 1'b1;
    end else begin
      tag_h[p*48 +: 48] = d[59:12]; typ_h[p*3 +: 3] = d[11:9]; bid_h[p*9 +: 9] = d[8:0]; wr_h[p] = 1'b1;
    end
    lat = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk); #1; lat++;
      got = net ? ack_n[p] : ack_h[p];
    end
    if (!got) begin
      ncmp++; nmis++;
      $display("FAIL write_ack_timeout_p%0d actual=no_ack required=ack", p);
    end
    if (net) wr_n[p] = 1'b0; else wr_h[p] = 1'b0;
  endtask

  task automatic wait_issue(input int p);
    int n = 0;
    while (!bwr[p] && n < 50) begin @(negedge clk); #1; n++; end
    chk($sformatf("issue_seen_p%0d", p), {63'd0, bwr[p]}, 64'd1);
  endtask

  task automatic wait_drain(input int p);
    int n = 0;
    while ((level_of(p) != 0 || bwr[p] || exp_q[p].size() != 0) && n < 400) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("drain_level_p%0d", p), {59'd0, level_of(p)}, 64'd0);
    chk($sformatf("drain_sb_p%0d", p), exp_q[p].size(), 64'd0);
  endtask

  task automatic send_burst(input int p, input bit net);
    int lat;
    logic [59:0] d;
    for (int i = 0; i < 6; i++) begin
      d = mk(48'hC000_0000_0000 + 48'(p * 16 + i), 3'(i), 9'(p * 32 + i + 1));
      exp_q[p].push_back(d);
      do_write(p, net, d, lat);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, c0, o0, c1;
    logic [59:0] d;
    // Reset state
    #1;
    chk("rst_bufid_wr", {60'd0, bwr}, 64'd0);
    chk("rst_acks", {56'd0, ack_h, ack_n}, 64'd0);
    chk("rst_pulses", {56'd0, cntp, ovfp}, 64'd0);
    chk("rst_level", {44'd0, lvl}, 64'd0);
    chk("rst_bufid", {28'd0, o_bid}, 64'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // 1: single host write on port 0
    d = mk(48'h0000_1111_0001, 3'd3, 9'h005);
    exp_q[0].push_back(d);
    do_write(0, 1'b0, d, lat);
    chk("t1_ack_latency", lat, 1);
    chk("t1_level_after_accept", {59'd0, level_of(0)}, 64'd1);
    wait_drain(0);
    chk("t1_cnt", cnt_seen[0], 1);

    // 2: simultaneous host and network writes on port 1, host preferred
    exp_q[1].push_back(mk(48'h0000_2222_0001, 3'd1, 9'h011));
    exp_q[1].push_back(mk(48'h0000_2222_0002, 3'd2, 9'h022));
    fork
      do_write(1, 1'b0, mk(48'h0000_2222_0001, 3'd1, 9'h011), lat);
      do_write(1, 1'b1, mk(48'h0000_2222_0002, 3'd2, 9'h022), lat2);
    join
    chk("t2_host_latency", lat, 1);
    chk("t2_net_latency", lat2, 2);
    wait_drain(1);
    chk("t2_cnt", cnt_seen[1], 2);

    // 3: fill port 0 with the gate closed, then a 17th held until space frees
    gate[0] = 1'b0;
    o0 = ovf_seen[0];
    c0 = cnt_seen[0];
    for (int i = 0; i < 16; i++) begin
      d = mk(48'hA000_0000_0000 + 48'(i), 3'(i), 9'h100 + 9'(i));
      exp_q[0].push_back(d);
      do_write(0, 1'b0, d, lat);
    end
    chk("t3_level_full", {59'd0, level_of(0)}, 64'd16);
    d = mk(48'hA000_0000_00FF, 3'd7, 9'h1FF);
    exp_q[0].push_back(d);
    fork
      begin
        do_write(0, 1'b0, d, lat);
        chk("t3_pops_before_17th_ack", cnt_seen[0] - c0, 1);
      end
      begin
        repeat (5) begin @(negedge clk); #1; end
        chk("t3_level_held", {59'd0, level_of(0)}, 64'd16);
        chk("t3_no_ack_while_full", {63'd0, ack_h[0]}, 64'd0);
        chk("t3_overflow_once", ovf_seen[0] - o0, 1);
        gate[0] = 1'b1;
      end
    join
    wait_drain(0);
    chk("t3_overflow_total", ovf_seen[0] - o0, 1);
    chk("t3_cnt", cnt_seen[0] - c0, 17);

    // 4: slow ack with gate dropping mid-request on port 1
    delay[1] = 5;
    c1 = cnt_seen[1];
    d = mk(48'hB000_0000_0001, 3'd5, 9'h0B1);
    exp_q[1].push_back(d);
    do_write(1, 1'b0, d, lat);
    wait_issue(1);
    repeat (2) begin @(negedge clk); #1; end
    gate[1] = 1'b0;
    chk("t4_req_held_after_gate_close", {63'd0, bwr[1]}, 64'd1);
    wait_drain(1);
    chk("t4_single_pop", cnt_seen[1] - c1, 1);
    d = mk(48'hB000_0000_0002, 3'd6, 9'h0B2);
    exp_q[1].push_back(d);
    do_write(1, 1'b0, d, lat);
    repeat (10) begin @(negedge clk); #1; end
    chk("t4_no_issue_gate_closed", {63'd0, bwr[1]}, 64'd0);
    chk("t4_level_pending", {59'd0, level_of(1)}, 64'd1);
    gate[1] = 1'b1;
    wait_drain(1);
    chk("t4_cnt", cnt_seen[1] - c1, 2);
    delay[1] = 0;

    // 5: reset with queued and in-flight descriptors
    gate[0] = 1'b0;
    delay[1] = 60;
    for (int i = 0; i < 7; i++) begin
      d = mk(48'hD000_0000_0000 + 48'(i), 3'd1, 9'h0D0 + 9'(i));
      exp_q[0].push_back(d);
      do_write(0, 1'b0, d, lat);
    end
    d = mk(48'hD100_0000_0000, 3'd2, 9'h0E0);
    exp_q[1].push_back(d);
    do_write(1, 1'b0, d, lat);
    wait_issue(1);
    chk("t5_level_before_reset", {59'd0, level_of(0)}, 64'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_bufid_wr", {60'd0, bwr}, 64'd0);
    chk("t5_rst_level", {44'd0, lvl}, 64'd0);
    chk("t5_rst_data", {28'd0, o_bid} | {52'd0, o_typ} | {16'd0, o_tag}, 64'd0);
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    c0 = cnt_seen[0] + cnt_seen[1];
    delay[1] = 0;
    gate = '1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin @(negedge clk); #1; end
    chk("t5_no_issue_after_reset", {60'd0, bwr}, 64'd0);
    chk("t5_level_after_reset", {44'd0, lvl}, 64'd0);
    chk("t5_no_cnt_after_reset", cnt_seen[0] + cnt_seen[1] - c0, 0);

    // 6: concurrent traffic on all four ports
    for (int p = 0; p < NP; p++) begin
      delay[p] = p;
      cnt_seen[p] = 0;
    end
    fork
      send_burst(0, 1'b0);
      send_burst(1, 1'b0);
      send_burst(2, 1'b1);
      send_burst(3, 1'b1);
    join
    for (int p = 0; p < NP; p++) begin
      wait_drain(p);
      chk($sformatf("t6_cnt_p%0d", p), cnt_seen[p], 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule

`default_nettype wire
